// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory handshake plus IF/ID slot and pipeline control signals.
interface if_fetch_unit_if;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        valid;
   modport master (
      input  freeze, branch_taken, branch_addr, mem_ready, mem_rdata,
      output mem_req, mem_addr, PC, Instruction, valid
   );
   modport slave (
      output freeze, branch_taken, branch_addr, mem_ready, mem_rdata,
      input  mem_req, mem_addr, PC, Instruction, valid
   );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: program counter, req/ready instruction fetch and one-entry IF/ID output slot
// with freeze stall and branch redirect that discards wrong-path fetches.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic            clk,
   input logic            rst,
   if_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
   state_t      r_state;
   logic [31:0] r_pc, r_req_addr, r_pc_out, r_instr;
   logic        r_valid;
   logic        w_can_issue, w_req, w_load, w_hold;
   logic [31:0] w_next;
   assign w_can_issue = !r_valid || !bus.freeze;
   // Request is gated by reset so it drops immediately even mid-transaction.
   assign w_req  = rst && (r_state == IDLE ? (w_can_issue && !bus.branch_taken) : 1'b1);
   assign w_next = (r_state == IDLE ? r_pc : r_req_addr) + 32'd4;
   assign w_load = w_req && bus.mem_ready && r_state != FLUSH && !bus.branch_taken;
   assign w_hold = r_valid && bus.freeze && !bus.branch_taken;
   assign bus.mem_req     = w_req;
   assign bus.mem_addr    = r_state == IDLE ? r_pc : r_req_addr;
   assign bus.PC          = r_pc_out;
   assign bus.Instruction = r_instr;
   assign bus.valid       = r_valid;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= '0;
         r_pc_out   <= '0;
         r_instr    <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_valid  <= w_load || w_hold;
         r_pc_out <= w_load ? w_next : w_hold ? r_pc_out : '0;
         r_instr  <= w_load ? bus.mem_rdata : w_hold ? r_instr : '0;
         r_pc     <= bus.branch_taken ? bus.branch_addr : w_load ? w_next : r_pc;
         if (r_state == IDLE && w_req && !bus.mem_ready)
            r_req_addr <= r_pc;
         r_state <= r_state == IDLE ? ((w_req && !bus.mem_ready) ? BUSY : IDLE) :
                    r_state == BUSY ? (bus.mem_ready ? IDLE : bus.branch_taken ? FLUSH : BUSY) :
                    (bus.mem_ready ? IDLE : FLUSH);
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized fetch traffic; a stream-level scoreboard checks
// every instruction handed to decode against the expected program-order fetch stream.
module tb_if_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_0000;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   if_fetch_unit_if bus();
   if_fetch_unit #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {logic [31:0] pc; logic [31:0] ins;} exp_t;
   exp_t        exp_q[$];
   logic [31:0] next_exp = RPC;
   int          vectors = 0, miscompares = 0;
   int          wait_cfg = 0, wait_left = 0;
   bit          rand_wait = 1'b0, in_req = 1'b0;
   bit          pend = 1'b0, prev_br = 1'b0;
   logic [31:0] pend_addr = '0;
   int          idle = 0;
   bit          found;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic restart_stream(input logic [31:0] a);
      exp_q.delete();
      next_exp = a;
   endtask

   // Drive one cycle's inputs at posedge+1, then let the memory answer the visible request.
   task automatic apply(input bit fz, input bit br, input logic [31:0] ba);
      exp_t e;
      bus.freeze = fz;
      bus.branch_taken = br;
      bus.branch_addr = ba;
      if (br) restart_stream(ba);
      while (exp_q.size() < 4) begin
         e.pc = next_exp + 32'd4;
         e.ins = word(next_exp);
         exp_q.push_back(e);
         next_exp += 32'd4;
      end
      #1;
      if (!bus.mem_req) begin
         in_req = 1'b0;
         bus.mem_ready = 1'b0;
      end else begin
         if (!in_req) begin
            in_req = 1'b1;
            wait_left = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
         end
         bus.mem_ready = (wait_left == 0);
         bus.mem_rdata = bus.mem_ready ? word(bus.mem_addr) : $urandom;
         if (wait_left == 0) in_req = 1'b0;
         else wait_left--;
      end
   endtask

   task automatic step(input bit fz, input bit br, input logic [31:0] ba);
      @(posedge clk);
      #1;
      apply(fz, br, ba);
   endtask

   // Called at posedge+2: assert reset mid-cycle, check, release on the second following edge.
   task automatic reset_now();
      #2;
      rst = 1'b0;
      in_req = 1'b0;
      restart_stream(RPC);
      #1;
      chk("rst_req", 32'(bus.mem_req), 0);
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_pc", bus.PC, 0);
      chk("rst_ins", bus.Instruction, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply(1'b0, 1'b0, 32'h0);
      chk("restart_req", 32'(bus.mem_req), 1);
      chk("restart_addr", bus.mem_addr, RPC);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         pend = 1'b0;
         prev_br = 1'b0;
         idle = 0;
      end else begin
         if (pend) begin
            chk("req_hold", 32'(bus.mem_req), 1);
            chk("addr_hold", bus.mem_addr, pend_addr);
         end
         if (prev_br) begin
            chk("flush_valid", 32'(bus.valid), 0);
            chk("flush_pc", bus.PC, 0);
         end
         if (bus.valid && !bus.freeze && !bus.branch_taken) begin
            idle = 0;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_empty: got PC %h expected no delivery", bus.PC);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", bus.PC, e.pc);
               chk("sb_ins", bus.Instruction, e.ins);
            end
         end else if (bus.freeze || bus.branch_taken) begin
            idle = 0;
         end else begin
            idle++;
            if (idle == 13) begin
               vectors++;
               miscompares++;
               $display("FAIL progress: got %0d idle cycles expected at most 12", idle);
            end
         end
         pend = bus.mem_req && !bus.mem_ready;
         pend_addr = bus.mem_addr;
         prev_br = bus.branch_taken;
      end
   end

   initial begin
      bus.freeze = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_addr = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      // zero-wait streaming
      reset_now();
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk("stream_addr", bus.mem_addr, 32'(4 * i));
         chk("stream_valid", 32'(bus.valid), 1);
         chk("stream_pc", bus.PC, 32'(4 * i));
      end
      // three wait states
      wait_cfg = 3;
      reset_now();
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk("wait_addr", bus.mem_addr, 0);
         chk("wait_valid", 32'(bus.valid), 0);
      end
      wait_cfg = 0;
      step(1'b0, 1'b0, 32'h0);
      chk("wait_valid_rise", 32'(bus.valid), 1);
      chk("wait_pc", bus.PC, 32'h4);
      // freeze with a full slot
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 32'h0);
         chk("frz_req", 32'(bus.mem_req), 0);
         chk("frz_pc", bus.PC, 32'h8);
         chk("frz_ins", bus.Instruction, word(32'h4));
      end
      step(1'b0, 1'b0, 32'h0);
      chk("frz_release_req", 32'(bus.mem_req), 1);
      chk("frz_release_addr", bus.mem_addr, 32'h8);
      // branch while BUSY
      wait_cfg = 3;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h100);
      wait_cfg = 0;
      step(1'b0, 1'b0, 32'h0);
      chk("br_busy_valid", 32'(bus.valid), 0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step(1'b0, 1'b0, 32'h0);
         found = bus.mem_req && bus.mem_addr == 32'h100;
      end
      chk("br_target_seen", 32'(found), 1);
      step(1'b0, 1'b0, 32'h0);
      chk("br_target_pc", bus.PC, 32'h104);
      // branch together with freeze, slot full
      step(1'b1, 1'b1, 32'h200);
      chk("brfrz_req", 32'(bus.mem_req), 0);
      wait_cfg = 1;
      step(1'b0, 1'b0, 32'h0);
      chk("brfrz_valid", 32'(bus.valid), 0);
      chk("brfrz_addr", bus.mem_addr, 32'h200);
      // branch on the same cycle as mem_ready in BUSY
      step(1'b0, 1'b1, 32'h300);
      chk("brrdy_req", 32'(bus.mem_req), 1);
      step(1'b0, 1'b0, 32'h0);
      chk("brrdy_valid", 32'(bus.valid), 0);
      chk("brrdy_req_next", 32'(bus.mem_req), 1);
      chk("brrdy_addr", bus.mem_addr, 32'h300);
      // reset in the middle of a request
      wait_cfg = 3;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b0, 1'b0, 32'h0);
         found = bus.mem_req && !bus.mem_ready;
      end
      chk("busy_seen", 32'(found), 1);
      wait_cfg = 0;
      reset_now();
      // address wrap
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_pc", bus.PC, 32'h0);
      chk("wrap_next_addr", bus.mem_addr, 32'h0);
      // randomized traffic
      rand_wait = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ba;
         ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         if (i == 1500) reset_now();
         else step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, ba);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit producing the `PC_in`/`Instruction_in` pair consumed by the IF/ID pipeline register. It owns the program counter, issues word reads to instruction memory over a req/ready handshake with arbitrary wait states, and holds one fetched instruction in an output slot until the decode side accepts it. It honours `freeze` from hazard detection and redirects on `branch_taken`, discarding any in-flight or buffered wrong-path fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `freeze` input 1: downstream stall; output slot is not consumed this cycle.
- `branch_taken` input 1: redirect request, higher priority than `freeze`.
- `branch_addr` input 32: redirect target, word aligned.
- `mem_req` output 1: read request to instruction memory.
- `mem_addr` output 32: read address, stable while `mem_req` high and not yet acknowledged.
- `mem_ready` input 1: memory acknowledge; `mem_rdata` valid in this cycle.
- `mem_rdata` input 32: read data.
- `PC` output 32: fetch address + 4 of the buffered instruction.
- `Instruction` output 32: buffered instruction word.
- `valid` output 1: output slot holds a valid instruction.

## Operation
- Registers: `pc` (next fetch address), `req_addr` (address of outstanding request), output slot {`valid`, `PC`, `Instruction`}, state.
- Slot consumed in any cycle with `valid`=1 and `freeze`=0. `can_issue` = (`valid`=0 or `freeze`=0).
- States: IDLE (no request outstanding), BUSY (request outstanding, result wanted), FLUSH (request outstanding, result discarded).
- IDLE: `mem_req` = `can_issue` and not `branch_taken`; `mem_addr` = `pc`.
  - `mem_req` and `mem_ready`: slot <= {1, pc+4, mem_rdata}; `pc` <= pc+4; stay IDLE.
  - `mem_req` and not `mem_ready`: `req_addr` <= `pc`; go BUSY.
- BUSY: `mem_req`=1, `mem_addr`=`req_addr`. Slot is empty throughout BUSY (issue only when slot empty or draining).
  - `mem_ready`, no branch: slot <= {1, req_addr+4, mem_rdata}; `pc` <= req_addr+4; go IDLE.
  - `branch_taken` and `mem_ready`: data dropped; `pc` <= `branch_addr`; go IDLE.
  - `branch_taken`, no `mem_ready`: `pc` <= `branch_addr`; go FLUSH.
- FLUSH: `mem_req`=1, `mem_addr`=`req_addr` (request never retracted). On `mem_ready`: data dropped, go IDLE. `branch_taken` in FLUSH: `pc` <= `branch_addr`, state unchanged.
- `branch_taken` in any state: slot `valid` <= 0 (`PC`, `Instruction` <= 0), no slot load that cycle.
- Slot drained with no new load: `valid` <= 0, `PC`/`Instruction` <= 0.
- Arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Reset (`rst`=0): immediately `valid`=0, `PC`=0, `Instruction`=0, `pc`=`RESET_PC`, state IDLE; `mem_req` forced 0 while `rst`=0, including reset asserted mid-request.
- First `mem_req` in first cycle after `rst` deasserts; zero-wait memory gives `valid`=1 on next edge.
- Latency: N wait cycles -> `valid` rises N+1 edges after first `mem_req` cycle.
- Throughput: one instruction per cycle with zero-wait memory and `freeze`=0.
- Branch penalty: IDLE needs one cycle with `mem_req`=0 before fetching `branch_addr`; from FLUSH, first target request the cycle after the discarded `mem_ready`.
- Slot outputs change only on clock edges; `mem_req`/`mem_addr` combinational from state, `pc`, `req_addr`, `valid`, `freeze`, `branch_taken`.

## Test plan
- Reset then zero-wait memory, `freeze`=0, RESET_PC=0 -> `mem_addr` 0,4,8 on consecutive cycles; `PC`=4,8,12 with `valid`=1 from second edge.
- Memory with 3 wait cycles -> `mem_addr` held at 0 for 4 cycles, `valid` rises after 4th edge with `PC`=4.
- `freeze`=1 for 5 cycles with slot full -> `PC`/`Instruction` stable, `mem_req`=0; release -> next fetch issued same cycle.
- `branch_taken`, `branch_addr`=32'h100, while BUSY with 2 wait cycles left -> old data dropped, `valid`=0, next request `mem_addr`=32'h100, `PC`=32'h104.
- `branch_taken` and `freeze` together with slot full -> `valid`=0 next edge; `branch_taken` same cycle as `mem_ready` in BUSY -> no slot load, IDLE.
- `rst` low mid-BUSY -> `mem_req`=0 immediately, outputs 0; after release fetch restarts at RESET_PC. Fetch at 32'hFFFF_FFFC -> `PC`=0.
